// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port 256x16 RAM arbiter.
// The init sweep is compiled in with RAM_ARB_INIT_EN.
package ram_arb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] INIT_VAL_DEF = 16'h0000;

  localparam int P0 = 0;
  localparam int P1 = 1;

  typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/ram_rr_arb2.sv
// Two-way round-robin arbiter; 'last' remembers the most recently granted port.
module ram_rr_arb2
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic gnt0,
  output logic gnt1
);

  logic last;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        if (last == 1'(P0)) gnt1 = 1'b1;
        else                gnt0 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= 1'(P1);
    else if (gnt0) last <= 1'(P0);
    else if (gnt1) last <= 1'(P1);
  end

endmodule

// File: rtl/ram_256x16_arb.sv
// Arbiter/sequencer sharing one ram_256x16A macro between two req/gnt clients.
// Define RAM_ARB_INIT_EN to clear the array with a 256-cycle sweep after reset.
module ram_256x16_arb
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(INIT_VAL_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvld0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvld1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_wen,
  output logic              ram_cen,
  input  logic [DATA_W-1:0] ram_q
);

  // Handshake: a transfer happens in any cycle with reqN && gntN; the client
  // holds reqN and its command stable until then, and read data comes back on
  // rdata with rvldN exactly one cycle after the accepting cycle.
  logic              init_act;
  logic [ADDR_W-1:0] init_a;
  logic              arb_en;

`ifdef RAM_ARB_INIT_EN
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt, init_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // The counter wraps to 0 on the same edge that leaves INIT.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    if (state == INIT) begin
      init_cnt_nxt = init_cnt + ADDR_W'(1);
      if (&init_cnt) state_nxt = RUN;
    end
  end

  assign init_act = (state == INIT);
  assign init_a   = init_cnt;
`else
  assign init_act = 1'b0;
  assign init_a   = '0;
`endif

  assign busy   = init_act;
  assign arb_en = rst_n & ~init_act;

  ram_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .en    (arb_en),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  // The macro stays deselected while reset is asserted.
  always_comb begin
    ram_cen = 1'b1;
    ram_wen = 1'b1;
    ram_a   = '0;
    ram_d   = '0;
    if (rst_n) begin
      if (init_act) begin
        ram_cen = 1'b0;
        ram_wen = 1'b0;
        ram_a   = init_a;
        ram_d   = INIT_VAL;
      end else if (gnt0) begin
        ram_cen = 1'b0;
        ram_wen = ~we0;
        ram_a   = addr0;
        ram_d   = wdata0;
      end else if (gnt1) begin
        ram_cen = 1'b0;
        ram_wen = ~we1;
        ram_a   = addr1;
        ram_d   = wdata1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvld0 <= 1'b0;
      rvld1 <= 1'b0;
    end else begin
      rvld0 <= gnt0 & ~we0;
      rvld1 <= gnt1 & ~we1;
    end
  end

  assign rdata = ram_q;

endmodule

// File: tb/tb_ram_256x16_arb.sv
// Randomized self-checking bench for ram_256x16_arb with a behavioural RAM macro.
// Works with or without RAM_ARB_INIT_EN defined.
module tb_ram_256x16_arb;

  localparam logic [15:0] INIT_VAL = 16'h0000;
`ifdef RAM_ARB_INIT_EN
  localparam int INIT_CYC = 256;
`else
  localparam int INIT_CYC = 0;
`endif

  typedef struct packed {
    logic        we;
    logic [7:0]  a;
    logic [15:0] d;
  } cmd_t;

  logic        clk, rst_n;
  logic        req0, we0, gnt0, rvld0;
  logic        req1, we1, gnt1, rvld1;
  logic [7:0]  addr0, addr1, ram_a;
  logic [15:0] wdata0, wdata1, rdata, ram_d, ram_q;
  logic        busy, ram_wen, ram_cen;

  ram_256x16_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvld0(rvld0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvld1(rvld1),
    .rdata(rdata), .busy(busy),
    .ram_a(ram_a), .ram_d(ram_d), .ram_wen(ram_wen), .ram_cen(ram_cen), .ram_q(ram_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // behavioural ram_256x16A: registered Q on reads, write at the edge
  logic [15:0] ram_mem [256];
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (!ram_wen) ram_mem[ram_a] <= ram_d;
      else          ram_q <= ram_mem[ram_a];
    end
  end

  // reference model
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_last;
  int          m_init;
  bit          m_rv0, m_rv1;
  logic [15:0] ref_mem [256];
  bit          ref_known [256];
  logic [16:0] exp_q0[$], exp_q1[$];
  cmd_t        q0[$], q1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic [7:0] a, input logic [15:0] d);
    cmd_t c;
    c.we = we; c.a = a; c.d = d;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd(input int amax);
    cmd_t c;
    c.we = 1'($urandom_range(0, 1));
    c.a  = 8'($urandom_range(0, amax));
    c.d  = 16'($urandom);
    return c;
  endfunction

  task automatic model_reset();
    m_last = 1;
    m_init = INIT_CYC;
    m_rv0  = 1'b0;
    m_rv1  = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    q0.delete();
    q1.delete();
  endtask

  // driver + scoreboard for one clock; entered and left on a falling edge
  task automatic cycle();
    cmd_t c0, c1, cg;
    bit r0, r1;
    int g;
    logic [16:0] e;
    r0 = (q0.size() > 0);
    r1 = (q1.size() > 0);
    c0 = r0 ? q0[0] : rnd_cmd(255);
    c1 = r1 ? q1[0] : rnd_cmd(255);
    req0 = r0; we0 = c0.we; addr0 = c0.a; wdata0 = c0.d;
    req1 = r1; we1 = c1.we; addr1 = c1.a; wdata1 = c1.d;
    #1;
    g = -1;
    if (m_init > 0) begin
      check("busy_init", 32'(busy), 32'd1);
      check("cen_init", 32'(ram_cen), 32'd0);
      check("wen_init", 32'(ram_wen), 32'd0);
      check("a_init", 32'(ram_a), 32'(INIT_CYC - m_init));
      check("d_init", 32'(ram_d), 32'(INIT_VAL));
    end else begin
      if (r0 && r1) g = (m_last == 0) ? 1 : 0;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
      check("busy_run", 32'(busy), 32'd0);
      if (g >= 0) begin
        cg = (g == 1) ? c1 : c0;
        check("cen_gnt", 32'(ram_cen), 32'd0);
        check("wen_gnt", 32'(ram_wen), 32'(!cg.we));
        check("a_gnt", 32'(ram_a), 32'(cg.a));
        check("d_gnt", 32'(ram_d), 32'(cg.d));
      end else begin
        check("cen_idle", 32'(ram_cen), 32'd1);
        check("wen_idle", 32'(ram_wen), 32'd1);
        check("a_idle", 32'(ram_a), 32'd0);
        check("d_idle", 32'(ram_d), 32'd0);
      end
    end
    check("gnt0", 32'(gnt0), 32'(g == 0));
    check("gnt1", 32'(gnt1), 32'(g == 1));
    check("rvld0", 32'(rvld0), 32'(m_rv0));
    check("rvld1", 32'(rvld1), 32'(m_rv1));
    if (m_rv0 && exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      if (e[16]) check("rdata0", 32'(rdata), 32'(e[15:0]));
    end
    if (m_rv1 && exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      if (e[16]) check("rdata1", 32'(rdata), 32'(e[15:0]));
    end
    // advance the model across the coming rising edge
    m_rv0 = 1'b0;
    m_rv1 = 1'b0;
    if (m_init > 0) begin
      ref_mem[INIT_CYC - m_init]   = INIT_VAL;
      ref_known[INIT_CYC - m_init] = 1'b1;
      m_init--;
    end else if (g >= 0) begin
      cg = (g == 1) ? c1 : c0;
      if (cg.we) begin
        ref_mem[cg.a]   = cg.d;
        ref_known[cg.a] = 1'b1;
      end else if (g == 0) begin
        exp_q0.push_back({ref_known[cg.a], ref_mem[cg.a]});
        m_rv0 = 1'b1;
      end else begin
        exp_q1.push_back({ref_known[cg.a], ref_mem[cg.a]});
        m_rv1 = 1'b1;
      end
      m_last = g;
      if (g == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_rv0 || m_rv1) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  // asynchronous reset pulse started between clock edges
  task automatic reset_pulse(input bit hold_req);
    req0 = hold_req; req1 = hold_req;
    we0 = 1'b0; we1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_rvld0", 32'(rvld0), 32'd0);
    check("rst_rvld1", 32'(rvld1), 32'd0);
    check("rst_cen", 32'(ram_cen), 32'd1);
    check("rst_wen", 32'(ram_wen), 32'd1);
    check("rst_busy", 32'(busy), 32'(INIT_CYC > 0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_known[i] = 1'b0;
    rst_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(negedge clk);
    reset_pulse(1'b1);

    // request from port 1 pending while the sweep runs, then reset mid-sweep
    q1.push_back(mk(1'b0, 8'hFF, 16'h0));
    repeat (100) cycle();
    q0.push_back(mk(1'b0, 8'h11, 16'h0));
    cycle();
    reset_pulse(1'b0);

    // full sweep, then port 1 alone gets the first RUN cycle
    q1.push_back(mk(1'b0, 8'hFF, 16'h0));
    run_drain(400);
    q0.push_back(mk(1'b0, 8'h00, 16'h0));
    run_drain(20);

    // port 0 write then read
    q0.push_back(mk(1'b1, 8'h12, 16'hBEEF));
    q0.push_back(mk(1'b0, 8'h12, 16'h0));
    run_drain(20);

    // seed 0x40 and give port 1 the last grant before the dual-request run
    q0.push_back(mk(1'b1, 8'h40, 16'hAAAA));
    run_drain(20);
    q1.push_back(mk(1'b1, 8'h55, 16'h5555));
    run_drain(20);
    q0.push_back(mk(1'b0, 8'h12, 16'h0));
    q0.push_back(mk(1'b0, 8'h40, 16'h0));
    q0.push_back(mk(1'b0, 8'h55, 16'h0));
    q1.push_back(mk(1'b0, 8'h40, 16'h0));
    q1.push_back(mk(1'b0, 8'h55, 16'h0));
    q1.push_back(mk(1'b0, 8'h12, 16'h0));
    run_drain(40);

    // same-cycle write by port 1 and read by port 0 of 0x40
    q1.push_back(mk(1'b1, 8'h40, 16'h1234));
    q0.push_back(mk(1'b0, 8'h40, 16'h0));
    q0.push_back(mk(1'b0, 8'h40, 16'h0));
    run_drain(20);

    // random traffic on a small address window to force collisions
    for (int i = 0; i < 1500; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) != 0) q0.push_back(rnd_cmd(15));
      if (q1.size() < 2 && $urandom_range(0, 2) != 0) q1.push_back(rnd_cmd(15));
      cycle();
    end
    run_drain(40);

    // reset in the middle of traffic drops pending reads
    q0.push_back(mk(1'b0, 8'h03, 16'h0));
    q1.push_back(mk(1'b0, 8'h04, 16'h0));
    cycle();
    reset_pulse(1'b1);
    run_drain(400);
    for (int i = 0; i < 300; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 1) != 0) q0.push_back(rnd_cmd(7));
      if (q1.size() < 2 && $urandom_range(0, 1) != 0) q1.push_back(rnd_cmd(7));
      cycle();
    end
    run_drain(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
